// File: rtl/stream_arbiter_rr.sv
// N-to-1 round-robin merger for stb/ack word streams, tagging each word with its
// source channel, plus a maskable exception aggregator that runs beside the arbiter.
module stream_arbiter_rr #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CH_BITS  = 2,
  parameter int STICKY   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_stb,
  output logic [CHANNELS-1:0]       in_ack,
  output logic [WIDTH-1:0]          out_data,
  output logic [CH_BITS-1:0]        out_channel,
  output logic                      out_stb,
  input  logic                      out_ack,
  input  logic [CHANNELS-1:0]       exception_in,
  input  logic [CHANNELS-1:0]       exception_mask,
  output logic [CHANNELS-1:0]       exception_src,
  output logic                      exception,
  output logic [1:0]                dbg_state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // Handshake: a word moves on a rising edge where stb and ack are both high;
  // producers keep stb/data stable until they see ack, and in_ack is one-hot or zero.

  logic [1:0]          state_q, state_d;
  logic [CH_BITS-1:0]  grant_q, grant_d;
  logic [CH_BITS-1:0]  last_grant_q, last_grant_d;
  logic [CHANNELS-1:0] in_ack_q, in_ack_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [CH_BITS-1:0]  out_channel_q, out_channel_d;
  logic                out_stb_q, out_stb_d;
  logic [CHANNELS-1:0] exc_src_q, exc_src_d;
  logic                exc_q, exc_d;

  logic [CH_BITS-1:0]  pick_idx;
  int                  best_dist;
  logic [WIDTH-1:0]    sel_data;
  logic                sel_stb;

  // Winner is the requester with the smallest distance after last_grant, so the
  // search order wraps from CHANNELS-1 back to 0.
  always_comb begin
    pick_idx  = '0;
    best_dist = CHANNELS;
    for (int k = 0; k < CHANNELS; k++) begin
      if (in_stb[k] && (((k + CHANNELS - 1 - int'(last_grant_q)) % CHANNELS) < best_dist)) begin
        best_dist = (k + CHANNELS - 1 - int'(last_grant_q)) % CHANNELS;
        pick_idx  = CH_BITS'(k);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_stb  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_q == CH_BITS'(k)) begin
        sel_data = in_data[k*WIDTH +: WIDTH];
        sel_stb  = in_stb[k];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    in_ack_d      = in_ack_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_stb_d     = out_stb_q;
    case (state_q)
      ST_IDLE: begin
        if (|in_stb) begin
          grant_d = pick_idx;
          for (int k = 0; k < CHANNELS; k++) begin
            in_ack_d[k] = (pick_idx == CH_BITS'(k));
          end
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        in_ack_d = '0;
        if (sel_stb) begin
          out_data_d    = sel_data;
          out_channel_d = grant_q;
          out_stb_d     = 1'b1;
          state_d       = ST_SEND;
        end else begin
          // Producer withdrew its strobe: nothing transferred, priority unchanged.
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (out_ack) begin
          out_stb_d    = 1'b0;
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        in_ack_d  = '0;
        out_stb_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    if (STICKY != 0) exc_src_d = exc_src_q | exception_in;
    else             exc_src_d = exception_in;
    exc_d = |(exc_src_q & exception_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_grant_q  <= CH_BITS'(CHANNELS - 1);
      in_ack_q      <= '0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_stb_q     <= 1'b0;
      exc_src_q     <= '0;
      exc_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      in_ack_q      <= in_ack_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_stb_q     <= out_stb_d;
      exc_src_q     <= exc_src_d;
      exc_q         <= exc_d;
    end
  end

  assign in_ack        = in_ack_q;
  assign out_data      = out_data_q;
  assign out_channel   = out_channel_q;
  assign out_stb       = out_stb_q;
  assign exception_src = exc_src_q;
  assign exception     = exc_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_stream_arbiter_rr.sv
// Bench for stream_arbiter_rr: per-cycle comparison against a transaction-level
// model of the arbiter, plus directed scenarios with literal expected values.
module tb_stream_arbiter_rr;
  localparam int W  = 32;
  localparam int C  = 4;
  localparam int CB = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [C*W-1:0] in_data = '0;
  logic [C-1:0]   in_stb = '0;
  logic [C-1:0]   in_ack;
  logic [W-1:0]   out_data;
  logic [CB-1:0]  out_channel;
  logic           out_stb;
  logic           out_ack = 1'b0;
  logic [C-1:0]   exception_in = '0;
  logic [C-1:0]   exception_mask = '0;
  logic [C-1:0]   exception_src;
  logic           exception;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;
  int xfer_ch[$];
  int xfer_cyc[$];
  logic [W-1:0] exp_q[$];

  stream_arbiter_rr #(.WIDTH(W), .CHANNELS(C), .CH_BITS(CB), .STICKY(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
    .out_data(out_data), .out_channel(out_channel), .out_stb(out_stb), .out_ack(out_ack),
    .exception_in(exception_in), .exception_mask(exception_mask),
    .exception_src(exception_src), .exception(exception), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model
  // A word is "owned" by the arbiter from grant until downstream takes it; the
  // model tracks which step of that life the owned word is in.
  int           m_step;   // 0 free, 1 being accepted, 2 offered downstream
  int           m_owner;
  int           m_last;
  logic [C-1:0] e_ack;
  logic [W-1:0] e_data;
  int           e_ch;
  logic         e_stb;
  logic [C-1:0] e_src;
  logic         e_exc;

  function automatic int rr_pick(input logic [C-1:0] stb, input int last);
    for (int i = 1; i <= C; i++) begin
      if (stb[(last + i) % C]) return (last + i) % C;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst && out_stb && out_ack) begin
      xfer_ch.push_back(int'(out_channel));
      xfer_cyc.push_back(cyc);
      exp_q.push_back(out_data);
    end
    if (rst) begin
      m_step = 0; m_owner = 0; m_last = C - 1;
      e_ack = '0; e_data = '0; e_ch = 0; e_stb = 1'b0; e_src = '0; e_exc = 1'b0;
    end else begin
      e_exc = |(e_src & exception_mask);
      e_src = e_src | exception_in;
      if (m_step == 0) begin
        if (in_stb != 0) begin
          m_owner = rr_pick(in_stb, m_last);
          e_ack = '0;
          e_ack[m_owner] = 1'b1;
          m_step = 1;
        end
      end else if (m_step == 1) begin
        e_ack = '0;
        if (in_stb[m_owner]) begin
          e_data = in_data[m_owner*W +: W];
          e_ch   = m_owner;
          e_stb  = 1'b1;
          m_step = 2;
        end else begin
          m_step = 0;
        end
      end else if (out_ack) begin
        e_stb  = 1'b0;
        m_last = m_owner;
        m_step = 0;
      end
    end
  end

  // ---------------- compare process (opposite edge)
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_in_ack", 64'(in_ack), 64'(e_ack));
      check("m_out_stb", 64'(out_stb), 64'(e_stb));
      check("m_out_data", 64'(out_data), 64'(e_data));
      check("m_out_channel", 64'(out_channel), 64'(e_ch));
      check("m_exc_src", 64'(exception_src), 64'(e_src));
      check("m_exception", 64'(exception), 64'(e_exc));
    end
  end

  // ---------------- directed stimulus
  initial begin
    do_reset();
    cmp_en = 1'b1;
    check("reset_in_ack", 64'(in_ack), 64'd0);
    check("reset_out_stb", 64'(out_stb), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_exc_src", 64'(exception_src), 64'd0);

    // 1: single channel
    in_data[2*W +: W] = 32'hDEADBEEF;
    in_stb = 4'b0100;
    out_ack = 1'b1;
    tick();
    check("t1_in_ack", 64'(in_ack), 64'b0100);
    check("t1_out_stb_early", 64'(out_stb), 64'd0);
    tick();
    in_stb = '0;
    check("t1_in_ack_drop", 64'(in_ack), 64'd0);
    check("t1_out_stb", 64'(out_stb), 64'd1);
    check("t1_out_data", 64'(out_data), 64'hDEADBEEF);
    check("t1_out_channel", 64'(out_channel), 64'd2);
    tick();
    check("t1_out_stb_done", 64'(out_stb), 64'd0);
    tick();

    // 2: all channels requesting continuously
    rst = 1'b1;
    for (int k = 0; k < C; k++) in_data[k*W +: W] = 32'h100 + k;
    in_stb = 4'b1111;
    tick();
    tick();
    xfer_ch.delete();
    xfer_cyc.delete();
    exp_q.delete();
    rst = 1'b0;
    repeat (19) tick();
    check("t2_count", 64'(xfer_ch.size() >= 6), 64'd1);
    if (xfer_ch.size() >= 6) begin
      int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++) begin
        check("t2_channel_seq", 64'(xfer_ch[i]), 64'(exp_seq[i]));
        check("t2_data_seq", 64'(exp_q[i]), 64'(32'h100 + exp_seq[i]));
      end
      for (int i = 1; i < 6; i++) check("t2_spacing", 64'(xfer_cyc[i] - xfer_cyc[i-1]), 64'd3);
    end
    in_stb = '0;
    tick();
    tick();

    // 3: backpressure
    do_reset();
    in_data[1*W +: W] = 32'hA5A5_0001;
    in_stb = 4'b0010;
    out_ack = 1'b0;
    tick();
    tick();
    in_data[1*W +: W] = 32'hA5A5_0002;
    xfer_ch.delete();
    for (int i = 0; i < 10; i++) begin
      check("t3_out_stb_held", 64'(out_stb), 64'd1);
      check("t3_data_stable", 64'(out_data), 64'hA5A5_0001);
      check("t3_no_ack", 64'(in_ack), 64'd0);
      tick();
    end
    out_ack = 1'b1;
    in_stb = '0;
    tick();
    check("t3_released", 64'(out_stb), 64'd0);
    check("t3_one_xfer", 64'(xfer_ch.size()), 64'd1);
    tick();
    tick();
    check("t3_no_more_xfer", 64'(xfer_ch.size()), 64'd1);

    // 4: reset in SEND
    in_stb = 4'b0010;
    out_ack = 1'b0;
    tick();
    tick();
    check("t4_in_send", 64'(out_stb), 64'd1);
    in_stb = 4'b0011;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_out_stb_cleared", 64'(out_stb), 64'd0);
    check("t4_in_ack_cleared", 64'(in_ack), 64'd0);
    tick();
    check("t4_grant_ch0", 64'(in_ack), 64'b0001);
    out_ack = 1'b1;
    tick();
    in_stb = '0;
    tick();
    tick();

    // 5: sticky exceptions
    do_reset();
    exception_mask = 4'hF;
    exception_in = 4'b1000;
    tick();
    exception_in = '0;
    check("t5_src_set", 64'(exception_src), 64'b1000);
    check("t5_exc_lag", 64'(exception), 64'd0);
    tick();
    check("t5_exc_high", 64'(exception), 64'd1);
    check("t5_src_sticky", 64'(exception_src), 64'b1000);
    exception_mask = 4'h7;
    tick();
    check("t5_exc_masked", 64'(exception), 64'd0);
    check("t5_src_kept", 64'(exception_src), 64'b1000);
    exception_mask = 4'hF;

    // 6: strobe withdrawn during ACK
    do_reset();
    out_ack = 1'b1;
    in_stb = 4'b0001;
    tick();
    check("t6_in_ack", 64'(in_ack), 64'b0001);
    in_stb = '0;
    tick();
    check("t6_no_out_stb", 64'(out_stb), 64'd0);
    check("t6_in_ack_clear", 64'(in_ack), 64'd0);
    in_stb = 4'b0011;
    tick();
    check("t6_last_unchanged", 64'(in_ack), 64'b0001);
    tick();
    in_stb = '0;
    tick();
    tick();

    // mixed traffic checked only by the model
    for (int i = 0; i < 300; i++) begin
      in_stb = 4'($urandom_range(0, 15));
      out_ack = 1'($urandom_range(0, 1));
      exception_in = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      exception_mask = 4'($urandom_range(0, 15));
      for (int k = 0; k < C; k++) in_data[k*W +: W] = $urandom;
      if (i == 150) rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
